// File: rtl/fuzz_campaign_sequencer_if.sv
// AHB-Lite style link between the central fuzzer sequencer and a satellite.
//   hsel    select to satellite
//   hwrite  write enable
//   hwdata  mode word written to satellite
//   hrdata  satellite status returned to the sequencer
interface fuzz_campaign_sequencer_if;
    logic        hsel;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata;

    modport master (output hsel, hwrite, hwdata, input hrdata);
    modport slave  (input hsel, hwrite, hwdata, output hrdata);
endinterface

// File: rtl/fuzz_campaign_sequencer.sv
// Sequences a satellite fuzzer through campaigns: for each pass over the
// enabled modes (1=random, 2=mutated) it writes the mode word, waits one
// settle cycle, samples status for DWELL_CYCLES cycles, then parks the
// satellite with mode 0. Crash onsets are counted and time-stamped into a
// crash-log FIFO that persists across campaigns.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start, abort       campaign control
//   cfg_mode_mask      enabled modes, latched at start
//   cfg_rounds         mask passes per campaign (0 behaves as 1)
//   ahb                master side of the satellite link
//   busy, done         campaign in progress / 1-cycle end pulse
//   crash_count        saturating crash-onset count
//   proto_err          sticky illegal-status flag
//   log_valid/ready/data  crash-log FIFO head, {mode, ts} zero-extended
//   log_overflow       sticky: an entry was dropped on a full FIFO
module fuzz_campaign_sequencer #(
    parameter int DWELL_CYCLES = 64,
    parameter int LOG_DEPTH    = 8,
    parameter int TS_WIDTH     = 30
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [1:0]                      cfg_mode_mask,
    input  logic [7:0]                      cfg_rounds,
    fuzz_campaign_sequencer_if.master       ahb,
    output logic                            busy,
    output logic                            done,
    output logic [15:0]                     crash_count,
    output logic                            proto_err,
    output logic                            log_valid,
    input  logic                            log_ready,
    output logic [31:0]                     log_data,
    output logic                            log_overflow
);
    localparam int PW  = $clog2(LOG_DEPTH);
    localparam int CW  = PW + 1;
    localparam int DCW = $clog2(DWELL_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_WRITE, S_SETTLE, S_DWELL, S_PARK, S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic                abort_q, abort_d;
    logic [1:0]          mask_q;
    logic [7:0]          rounds_q;
    logic [7:0]          pass_q;
    logic [1:0]          mode_q;
    logic [DCW-1:0]      dwell_q;
    logic                prev_crash_q;
    logic [TS_WIDTH-1:0] ts_q;
    logic [15:0]         crash_count_q;
    logic                proto_err_q;
    logic                overflow_q;
    logic                zero_done_q;
    logic [31:0]         mem_q [LOG_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       cnt_q;

    logic [1:0]  next_mode;
    logic        last_pass;
    logic        go;
    logic        crash_w, legal_w, onset_w;
    logic        push_w, pop_w, full_w, push_ok;
    logic [31:0] entry_w;

    // Scan order within a pass is mode 1 then mode 2; mode_q remembers the
    // last mode visited so far in this pass (0 = none yet).
    always_comb begin
        next_mode = 2'd0;
        if (mode_q == 2'd0 && mask_q[0])      next_mode = 2'd1;
        else if (mode_q != 2'd2 && mask_q[1]) next_mode = 2'd2;
    end

    assign last_pass = (pass_q + 8'd1) == rounds_q;
    assign go        = (state_q == S_IDLE) && start && !abort && (cfg_mode_mask != 2'b00);

    assign crash_w = ahb.hrdata == {16'hDEAD, 14'b0, mode_q};
    assign legal_w = crash_w || (ahb.hrdata == 32'hF000_0000);
    assign onset_w = crash_w && !prev_crash_q;

    assign entry_w = 32'({mode_q, ts_q});
    assign full_w  = cnt_q == CW'(LOG_DEPTH);
    assign pop_w   = log_valid && log_ready;
    assign push_w  = (state_q == S_DWELL) && onset_w;
    assign push_ok = push_w && (!full_w || pop_w);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (go) state_d = S_SEL;
            end
            S_SEL: begin
                if (next_mode != 2'd0) state_d = S_WRITE;
                else if (last_pass)    state_d = S_FINISH;
            end
            S_WRITE:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_DWELL;
            S_DWELL:  if (dwell_q == DCW'(DWELL_CYCLES - 1)) state_d = S_PARK;
            S_PARK:   state_d = abort_q ? S_IDLE : S_SEL;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort always detours through PARK so the satellite is left idle.
        // Once parking for an abort, a held abort must not re-enter PARK.
        if (abort && state_q != S_IDLE && !(state_q == S_PARK && abort_q)) begin
            state_d = S_PARK;
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q        <= '0;
            rounds_q      <= '0;
            pass_q        <= '0;
            mode_q        <= '0;
            dwell_q       <= '0;
            prev_crash_q  <= 1'b0;
            ts_q          <= '0;
            crash_count_q <= '0;
            proto_err_q   <= 1'b0;
            overflow_q    <= 1'b0;
            zero_done_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            zero_done_q <= (state_q == S_IDLE) && start && !abort && (cfg_mode_mask == 2'b00);

            if (state_q != S_IDLE && ts_q != '1) ts_q <= ts_q + 1'b1;

            if (go) begin
                mask_q        <= cfg_mode_mask;
                rounds_q      <= (cfg_rounds == 8'd0) ? 8'd1 : cfg_rounds;
                pass_q        <= '0;
                mode_q        <= '0;
                ts_q          <= '0;
                crash_count_q <= '0;
                proto_err_q   <= 1'b0;
                overflow_q    <= 1'b0;
            end

            case (state_q)
                S_SEL: begin
                    if (next_mode != 2'd0) begin
                        mode_q <= next_mode;
                    end else if (!last_pass) begin
                        mode_q <= 2'd0;
                        pass_q <= pass_q + 8'd1;
                    end
                end
                S_SETTLE: begin
                    dwell_q      <= '0;
                    prev_crash_q <= 1'b0;
                end
                S_DWELL: begin
                    dwell_q      <= dwell_q + 1'b1;
                    prev_crash_q <= crash_w;
                    if (!legal_w) proto_err_q <= 1'b1;
                    if (onset_w && crash_count_q != 16'hFFFF)
                        crash_count_q <= crash_count_q + 16'd1;
                end
                default: ;
            endcase

            if (push_w && !push_ok) overflow_q <= 1'b1;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_w)      cnt_q <= cnt_q + 1'b1;
            else if (!push_ok && pop_w) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: the empty count masks stale contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= entry_w;
    end

    assign ahb.hsel   = (state_q == S_WRITE) || (state_q == S_PARK);
    assign ahb.hwrite = ahb.hsel;
    assign ahb.hwdata = (state_q == S_WRITE) ? {30'b0, mode_q} : 32'h0;

    assign busy         = state_q != S_IDLE;
    assign done         = (state_q == S_FINISH) || zero_done_q;
    assign crash_count  = crash_count_q;
    assign proto_err    = proto_err_q;
    assign log_valid    = cnt_q != '0;
    assign log_data     = log_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign log_overflow = overflow_q;
endmodule

// File: tb/tb_fuzz_campaign_sequencer.sv
module tb_fuzz_campaign_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, log_ready;
    logic [1:0]  cfg_mode_mask;
    logic [7:0]  cfg_rounds;
    logic        busy, done, proto_err, log_valid, log_overflow;
    logic [15:0] crash_count;
    logic [31:0] log_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] wq[$];   // expected AHB write data, in order
    logic [31:0] lq[$];   // expected crash-log pops, in order

    fuzz_campaign_sequencer_if bus();

    fuzz_campaign_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_mode_mask(cfg_mode_mask), .cfg_rounds(cfg_rounds),
        .ahb(bus), .busy(busy), .done(done), .crash_count(crash_count),
        .proto_err(proto_err), .log_valid(log_valid), .log_ready(log_ready),
        .log_data(log_data), .log_overflow(log_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboards whenever the DUT presents a write or a log pop.
    always @(negedge clk) begin
        if (bus.hsel && bus.hwrite) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL ahb_unexpected: got %h want none", bus.hwdata);
            end else check("ahb_write", bus.hwdata, wq.pop_front());
        end
        if (log_valid && log_ready) begin
            if (lq.size() == 0) begin
                total++; bad++;
                $display("FAIL log_unexpected: got %h want none", log_data);
            end else check("log_pop", log_data, lq.pop_front());
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Status at dwell sample k for a given pattern.
    function automatic logic [31:0] stat(input int pat, input int k, input logic [1:0] m);
        logic [31:0] crash;
        crash = {16'hDEAD, 14'b0, m};
        case (pat)
            1: return ((k >= 10 && k <= 12) || (k >= 30 && k <= 32)) ? crash : 32'hF000_0000;
            2: return (k % 2 == 1 && k <= 21) ? crash : 32'hF000_0000;
            3: return (k == 5) ? 32'hDEAD_0001 : 32'hF000_0000;
            4: return (k % 2 == 1 && k <= 5) ? crash : 32'hF000_0000;
            default: return 32'hF000_0000;
        endcase
    endfunction

    // Cycle t=1 is the first cycle after start is sampled; dwell sample k
    // of a single-visit campaign falls in cycle t=4+k.
    task automatic run(input logic [1:0] mask, input logic [7:0] rounds, input int pat,
                       input logic [1:0] m, input int abort_t, input int rst_t,
                       output int done_t);
        bit ended = 0;
        cfg_mode_mask = mask;
        cfg_rounds    = rounds;
        start = 1'b1;
        step();
        start  = 1'b0;
        done_t = -1;
        for (int t = 1; t < 600; t++) begin
            bus.hrdata = (t >= 4) ? stat(pat, t - 4, m) : 32'hF000_0000;
            abort = (t == abort_t);
            rst_n = (t != rst_t);
            if (done && done_t < 0) done_t = t;
            if (t > 1 && !busy && !done) begin ended = 1; break; end
            step();
        end
        abort = 1'b0;
        rst_n = 1'b1;
        bus.hrdata = 32'hF000_0000;
        if (!ended) check("campaign_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain(input string name);
        log_ready = 1'b1;
        repeat (12) step();
        log_ready = 1'b0;
        check({name, "_log_empty"}, {31'b0, log_valid}, 32'd0);
        check({name, "_log_q"}, lq.size(), 0);
        check({name, "_ahb_q"}, wq.size(), 0);
    endtask

    int dt;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; log_ready = 1'b0;
        cfg_mode_mask = 2'b00; cfg_rounds = 8'd0;
        bus.hrdata = 32'hF000_0000;
        repeat (3) step();
        check("reset_outs", {busy, done, proto_err, log_valid, log_overflow, bus.hsel, bus.hwrite, 9'b0, crash_count},
              32'h0);
        check("reset_data", log_data | bus.hwdata, 32'h0);
        rst_n = 1'b1;
        step();

        // start with empty mask: done next cycle, no activity
        run(2'b00, 8'd1, 0, 2'd0, -1, -1, dt);
        check("zero_mask_done_t", dt, 1);

        // 1: single random visit
        wq.push_back(32'd1); wq.push_back(32'd0);
        run(2'b01, 8'd1, 0, 2'd1, -1, -1, dt);
        check("t1_done_t", dt, 70);
        check("t1_crash", crash_count, 0);
        check("t1_nolog", {31'b0, log_valid}, 0);
        check("t1_ahb_q", wq.size(), 0);

        // 2: both modes, two passes (rounds=2)
        foreach (wq[i]) ;
        for (int r = 0; r < 2; r++) begin
            wq.push_back(32'd1); wq.push_back(32'd0);
            wq.push_back(32'd2); wq.push_back(32'd0);
        end
        run(2'b11, 8'd2, 0, 2'd0, -1, -1, dt);
        // run exits on the first cycle with busy low; done was the cycle before
        check("t2_done_seen", {31'b0, dt > 0}, 1);
        check("t2_busy_after", {31'b0, busy}, 0);
        check("t2_crash", crash_count, 0);
        check("t2_ahb_q", wq.size(), 0);

        // 3: mode 2, two crash windows -> ts 13 and 33
        wq.push_back(32'd2); wq.push_back(32'd0);
        run(2'b10, 8'd1, 1, 2'd2, -1, -1, dt);
        check("t3_crash", crash_count, 2);
        check("t3_perr", {31'b0, proto_err}, 0);
        lq.push_back(32'h8000_000D); lq.push_back(32'h8000_0021);
        drain("t3");

        // 4: eleven onsets into an 8-deep log with no consumer
        wq.push_back(32'd1); wq.push_back(32'd0);
        run(2'b01, 8'd0, 2, 2'd1, -1, -1, dt);
        check("t4_crash", crash_count, 11);
        check("t4_overflow", {31'b0, log_overflow}, 1);
        check("t4_rounds0_done", {31'b0, dt == 70}, 1);
        for (int k = 1; k <= 15; k += 2) lq.push_back(32'h4000_0000 | (3 + k));
        drain("t4");

        // 5: illegal status in mode 2, abort at dwell sample 10
        wq.push_back(32'd2); wq.push_back(32'd0);
        run(2'b10, 8'd1, 3, 2'd2, 14, -1, dt);
        check("t5_perr", {31'b0, proto_err}, 1);
        check("t5_no_done", dt, -1);
        check("t5_crash", crash_count, 0);
        check("t5_overflow_clr", {31'b0, log_overflow}, 0);
        drain("t5");

        // 6: reset mid-dwell with three entries logged
        wq.push_back(32'd1);
        run(2'b01, 8'd1, 4, 2'd1, -1, 24, dt);
        check("t6_outs", {busy, done, proto_err, log_valid, log_overflow, bus.hsel, bus.hwrite, 9'b0, crash_count},
              32'h0);
        check("t6_data", log_data | bus.hwdata, 32'h0);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
